ddr_app_responder: RTL
======================

Name: ddr_app_responder

Overview:
- Synthesizable responder for the MIG 7-series native app interface (the controller side of app_cmd/app_en/app_wdf_*/app_rd_data*).
- Stands in for the DDR3 MIG in simulation and on DDR-less builds, so ddr_ctrl can run unmodified against a BRAM-backed store.
- Implements calibration delay, in-order command execution, write-data/command decoupling, fixed read latency, and byte masking.

Parameters:
- ADDR_WIDTH, 30, app_addr width.
- MEM_AW, 10, log2 of the number of 256-bit words stored.
- CMD_DEPTH, 4, command queue depth (power of 2).
- WDF_DEPTH, 4, write data FIFO depth (power of 2).
- RD_LAT, 8, read latency stages (≥1, includes the memory output register).
- CALIB_CYCLES, 64, cycles from reset release to init_calib_complete.
- REF_PERIOD, 1024, refresh stall period (optional feature only).
- REF_STALL, 16, refresh stall length (optional feature only).

Ports:
- ui_clk  in  1  sole clock.
- sys_rst  in  1  reset; asynchronous, active-low.
- app_addr  in  ADDR_WIDTH  burst address in 32-bit column units.
- app_cmd  in  3  3'b000 write, 3'b001 read, other values are no-ops.
- app_en  in  1  command valid.
- app_rdy  out  1  command accepted when app_en & app_rdy.
- app_wdf_data  in  256  write data.
- app_wdf_mask  in  32  per-byte mask; 1 = byte not written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat; must equal app_wdf_wren.
- app_wdf_rdy  out  1  write data accepted when wren & wdf_rdy.
- app_rd_data  out  256  read data.
- app_rd_data_valid  out  1  read data strobe.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  ready indication.
- proto_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset: all outputs 0, queues empty, calibration counter 0.
- Calibration:
  - Counter runs after sys_rst deasserts.
  - init_calib_complete goes to 1 on cycle CALIB_CYCLES and stays 1 until reset.
  - Before that, app_rdy = app_wdf_rdy = 0 and all inputs are ignored.
- Ready signals:
  - app_rdy = calib & cmd queue not full (& not stalled, see Optional Feature). Registered; never combinationally dependent on app_en.
  - app_wdf_rdy = calib & WDF not full. Registered.
  - Both are computed from next-state occupancy, so a simultaneous push and pop at full keeps ready high.
- Write word index: app_addr[MEM_AW+2:3]. Bits [2:0] and bits above MEM_AW+2 are ignored, so addresses wrap modulo depth.
- Queue entries:
  - Command queue stores {cmd, word index}.
  - WDF stores {data, mask}.
  - Write data may arrive before, with, or after its command.
- Execute engine: one command per cycle, strictly in order from the queue head.
  - Write: waits while the WDF is empty; otherwise pops both the command and the WDF head and writes unmasked bytes in that cycle.
  - Read: pops the command, reads the memory, and the result enters an RD_LAT-deep valid/data pipeline.
  - Other cmd values: popped, no action.
- Latency:
  - Read accepted at cycle T with the queue empty: app_rd_data_valid is high at T+1+RD_LAT.
  - Multiple reads return in order, back-to-back if issued back-to-back.
- Ordering: a read behind a write to the same index returns the new data. The read cannot execute before the write commits.
- app_rd_data holds its last value while valid=0.
- proto_err sets, sticky until reset, on any of:
  - wren & !end;
  - end & !wren;
  - wren & !app_wdf_rdy after calibration (that beat is dropped);
  - en & !app_rdy after calibration (that command is dropped).
- Reset mid-operation: queues, pipeline and calibration are flushed immediately. Memory contents are not cleared.

Optional Feature:
- Macro DDR_APP_REFRESH_STALL_EN.
  - Defined: a free-running counter after calibration forces app_rdy = 0 for REF_STALL cycles every REF_PERIOD cycles. The execute engine also pauses, so reads in flight already in the pipeline still complete.
  - Undefined: no stall; counter logic is absent.

Decomposition:
- Package ddr_app_pkg:
  - APP_CMD_WR/APP_CMD_RD constants;
  - 256-bit data and 32-bit mask widths;
  - cmd-queue entry struct.
- One natural sub-module: ddr_app_sync_fifo (parameterized width/depth, full/empty/next-count). Instantiated for the command queue and the WDF.

Test Plan:
- Calibration: release sys_rst with CALIB_CYCLES=16 -> init_calib_complete, app_rdy and app_wdf_rdy rise on cycle 16; app_en pulsed at cycle 5 -> no read data and proto_err stays 0.
- Write then read: write addr 0x08, data 256'hA5…A5, mask 0; read 0x08 accepted at T -> app_rd_data_valid = app_rd_data_end = 1 at T+9 with data A5…A5.
- Decoupled data: write command at T, data at T+5, then read the same address -> read returns the new data, not the old contents.
- Mask: word preloaded with all-FF; write all-00 with mask 32'h0000000F -> read returns bytes [3:0] = FF and the rest 00.
- Backpressure: 4 write commands without data -> app_rdy = 0 after the 4th accept; supply 1 data beat -> app_rdy returns to 1 within 2 cycles.
- Error: wren=1, end=0 -> proto_err = 1 and stays 1 until sys_rst is asserted.

Source files
------------

// File: rtl/ddr_app_pkg.sv
// Shared types and constants for the MIG native app interface responder.
// Command codes, data/mask widths and the queue entry layouts.
package ddr_app_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam int DATA_W = 256;
  localparam int MASK_W = 32;
  localparam int IDX_W  = 32;

  typedef struct packed {
    logic [2:0]       cmd;
    logic [IDX_W-1:0] idx;
  } cmd_entry_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wdf_entry_t;

endpackage

// File: rtl/ddr_app_sync_fifo.sv
// Show-ahead synchronous FIFO. Ports: clk, rst_n, push/din, pop/dout,
// full, empty, next_count (occupancy after this cycle's push/pop).
module ddr_app_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   next_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  count;
  logic         do_push;
  logic         do_pop;

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign next_count = count + (AW+1)'(do_push)
                            - (AW+1)'(do_pop);
  assign dout       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ddr_app_responder.sv
// BRAM-backed stand-in for the MIG 7-series native app interface.
// Ports: ui_clk, sys_rst (async, active-low), app_* command/write/read
// channels, init_calib_complete, sticky proto_err.
// Optional: DDR_APP_REFRESH_STALL_EN adds periodic refresh stalls.
module ddr_app_responder
  import ddr_app_pkg::*;
#(
  parameter int ADDR_WIDTH   = 30,
  parameter int MEM_AW       = 10,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 4,
  parameter int RD_LAT       = 8,
  parameter int CALIB_CYCLES = 64,
  parameter int REF_PERIOD   = 1024,
  parameter int REF_STALL    = 16
) (
  input  logic                  ui_clk,
  input  logic                  sys_rst,
  input  logic [ADDR_WIDTH-1:0] app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [DATA_W-1:0]     app_wdf_data,
  input  logic [MASK_W-1:0]     app_wdf_mask,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [DATA_W-1:0]     app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  output logic                  init_calib_complete,
  output logic                  proto_err
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int WAW = $clog2(WDF_DEPTH);
  localparam int CLW = $clog2(CALIB_CYCLES + 1);

  logic           calib;
  logic           calib_nxt;
  logic [CLW-1:0] cal_cnt;
  logic           stall;
  logic           stall_nxt;

  cmd_entry_t     cmd_in;
  cmd_entry_t     head;
  wdf_entry_t     wdf_in;
  wdf_entry_t     wdf_head;
  logic           cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic           wdf_push, wdf_pop, wdf_full, wdf_empty;
  logic [CAW:0]   cmd_nc;
  logic [WAW:0]   wdf_nc;

  logic              is_wr, is_rd;
  logic              wr_fire, rd_fire;
  logic [MEM_AW-1:0] idx;
  logic              err_now;

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] dat [RD_LAT];

  assign calib_nxt = calib |
    (cal_cnt == CLW'(CALIB_CYCLES - 1));
  assign init_calib_complete = calib;

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cal_cnt <= '0;
      calib   <= 1'b0;
    end else begin
      if (!calib) cal_cnt <= cal_cnt + 1'b1;
      calib <= calib_nxt;
    end
  end

`ifdef DDR_APP_REFRESH_STALL_EN
  localparam int RW = $clog2(REF_PERIOD);
  logic [RW-1:0] ref_cnt;
  logic [RW-1:0] ref_nxt;

  always_comb begin
    ref_nxt = '0;
    if (calib) begin
      ref_nxt = (ref_cnt == RW'(REF_PERIOD - 1))
              ? '0 : ref_cnt + 1'b1;
    end
  end

  // Stall window sits at the tail of each period.
  assign stall = calib &
    (ref_cnt >= RW'(REF_PERIOD - REF_STALL));
  assign stall_nxt = calib_nxt &
    (ref_nxt >= RW'(REF_PERIOD - REF_STALL));

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) ref_cnt <= '0;
    else          ref_cnt <= ref_nxt;
  end
`else
  logic unused_ref;
  assign unused_ref = ^{REF_PERIOD, REF_STALL};
  assign stall      = 1'b0;
  assign stall_nxt  = 1'b0;
`endif

  assign cmd_in.cmd  = app_cmd;
  assign cmd_in.idx  = IDX_W'(app_addr[MEM_AW+2:3]);
  assign wdf_in.data = app_wdf_data;
  assign wdf_in.mask = app_wdf_mask;
  assign cmd_push    = app_en & app_rdy;
  assign wdf_push    = app_wdf_wren & app_wdf_rdy;

  ddr_app_sync_fifo #(
    .W     ($bits(cmd_entry_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_q (
    .clk        (ui_clk),
    .rst_n      (sys_rst),
    .push       (cmd_push),
    .din        (cmd_in),
    .pop        (cmd_pop),
    .dout       (head),
    .full       (cmd_full),
    .empty      (cmd_empty),
    .next_count (cmd_nc)
  );

  ddr_app_sync_fifo #(
    .W     ($bits(wdf_entry_t)),
    .DEPTH (WDF_DEPTH)
  ) u_wdf (
    .clk        (ui_clk),
    .rst_n      (sys_rst),
    .push       (wdf_push),
    .din        (wdf_in),
    .pop        (wdf_pop),
    .dout       (wdf_head),
    .full       (wdf_full),
    .empty      (wdf_empty),
    .next_count (wdf_nc)
  );

  assign is_wr = (head.cmd == APP_CMD_WR);
  assign is_rd = (head.cmd == APP_CMD_RD);
  assign idx   = head.idx[MEM_AW-1:0];

  // In-order engine: a write at the head blocks until its data exists.
  always_comb begin
    cmd_pop = 1'b0;
    wdf_pop = 1'b0;
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    if (!cmd_empty && !stall) begin
      unique case (1'b1)
        is_wr: begin
          if (!wdf_empty) begin
            cmd_pop = 1'b1;
            wdf_pop = 1'b1;
            wr_fire = 1'b1;
          end
        end
        is_rd: begin
          cmd_pop = 1'b1;
          rd_fire = 1'b1;
        end
        default: cmd_pop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge ui_clk) begin
    for (int b = 0; b < MASK_W; b++) begin
      if (wr_fire && !wdf_head.mask[b])
        mem[idx][8*b +: 8] <= wdf_head.data[8*b +: 8];
    end
  end

  // Stage 0 is the memory output register; data stages only load
  // on a valid arrival so the output holds between reads.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= rd_fire;
      if (rd_fire) dat[0] <= mem[idx];
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign app_rd_data       = dat[RD_LAT-1];
  assign app_rd_data_valid = vld[RD_LAT-1];
  assign app_rd_data_end   = vld[RD_LAT-1];

  assign err_now = calib & (
      (app_wdf_wren ^ app_wdf_end)
    | (app_wdf_wren & ~app_wdf_rdy)
    | (app_en & ~app_rdy));

  // Readies come from next-cycle occupancy so push+pop at full
  // keeps them asserted.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      app_rdy     <= 1'b0;
      app_wdf_rdy <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      app_rdy     <= calib_nxt & ~stall_nxt &
                     (cmd_nc != (CAW+1)'(CMD_DEPTH));
      app_wdf_rdy <= calib_nxt &
                     (wdf_nc != (WAW+1)'(WDF_DEPTH));
      if (err_now) proto_err <= 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{app_addr, head.idx, cmd_full, wdf_full};

endmodule
